// File: rtl/slot_accumulate_if.sv
// Correlator-side stream bundle for slot_accumulate: input words in, widened sums and error out.
interface slot_accumulate_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ACCUM = 6,
   parameter int unsigned TBITS = 4
);
   logic                    valid_i;
   logic                    last_i;
   logic signed [WIDTH-1:0] re_i;
   logic signed [WIDTH-1:0] im_i;
   logic                    valid_o;
   logic                    first_o;
   logic                    last_o;
   logic [TBITS-1:0]        slot_o;
   logic signed [ACCUM-1:0] re_o;
   logic signed [ACCUM-1:0] im_o;
   logic                    error_o;

   modport slave (
      input  valid_i, last_i, re_i, im_i,
      output valid_o, first_o, last_o, slot_o, re_o, im_o, error_o
   );

   modport master (
      output valid_i, last_i, re_i, im_i,
      input  valid_o, first_o, last_o, slot_o, re_o, im_o, error_o
   );
endinterface

// File: rtl/slot_accumulate.sv
// Per-slot visibility accumulator over COUNT frames, two-cycle pipeline through a slot memory.
// Define SLOT_ACCUMULATE_SATURATE_EN to clamp each add instead of wrapping.
module slot_accumulate #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ABITS = 2,
   parameter int unsigned TRATE = 12,
   parameter int unsigned TBITS = 4,
   parameter int unsigned COUNT = 3,
   parameter int unsigned CBITS = 2
) (
   input logic              clock,
   input logic              reset,
   slot_accumulate_if.slave bus
);
   localparam int unsigned ACCUM = WIDTH + ABITS;
   localparam logic [TBITS-1:0] LAST_SLOT  = TBITS'(TRATE - 1);
   localparam logic [CBITS-1:0] LAST_FRAME = CBITS'(COUNT - 1);

   typedef enum logic [1:0] {StFirst, StAccum, StEmit} state_e;

   state_e           state_q, state_d;
   logic [TBITS-1:0] slot_q, slot_d;
   logic [CBITS-1:0] frame_q, frame_d;
   logic             at_last, misalign;

   logic                    s1_valid, s1_emit, s1_use, s1_err;
   logic [TBITS-1:0]        s1_slot;
   logic [WIDTH-1:0]        s1_re, s1_im;
   logic [2*ACCUM-1:0]      rd_q;
   logic [2*ACCUM-1:0]      mem [TRATE];
   logic [ACCUM-1:0]        base_re, base_im, ext_re, ext_im, sum_re, sum_im;
   logic                    wr_en;

   function automatic logic [ACCUM-1:0] add_acc(input logic [ACCUM-1:0] a,
                                                input logic [ACCUM-1:0] b);
`ifdef SLOT_ACCUMULATE_SATURATE_EN
      logic [ACCUM:0] full;
      full = {a[ACCUM-1], a} + {b[ACCUM-1], b};
      if (full[ACCUM] != full[ACCUM-1]) begin
         return full[ACCUM] ? {1'b1, {(ACCUM-1){1'b0}}} : {1'b0, {(ACCUM-1){1'b1}}};
      end
      return full[ACCUM-1:0];
`else
      return a + b;
`endif
   endfunction

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      frame_d  = frame_q;
      at_last  = (slot_q == LAST_SLOT);
      misalign = bus.valid_i && (bus.last_i != at_last);
      if (bus.valid_i) begin
         if (misalign) begin
            // Misaligned framing: drop the partial sums and resynchronise on the next word.
            slot_d  = '0;
            frame_d = '0;
            state_d = StFirst;
         end else if (at_last) begin
            slot_d  = '0;
            frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
            if (frame_d == '0) begin
               state_d = StFirst;
            end else if (frame_d == LAST_FRAME) begin
               state_d = StEmit;
            end else begin
               state_d = StAccum;
            end
         end else begin
            slot_d = slot_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StFirst;
         slot_q   <= '0;
         frame_q  <= '0;
         s1_valid <= 1'b0;
         s1_emit  <= 1'b0;
         s1_use   <= 1'b0;
         s1_err   <= 1'b0;
         s1_slot  <= '0;
         s1_re    <= '0;
         s1_im    <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         frame_q  <= frame_d;
         s1_valid <= bus.valid_i;
         if (bus.valid_i) begin
            s1_emit <= (state_q == StEmit) || (COUNT == 1);
            s1_use  <= (state_q != StFirst);
            s1_err  <= misalign;
            s1_slot <= slot_q;
            s1_re   <= bus.re_i;
            s1_im   <= bus.im_i;
         end
      end
   end

   always_comb begin
      base_re = s1_use ? rd_q[2*ACCUM-1:ACCUM] : '0;
      base_im = s1_use ? rd_q[ACCUM-1:0] : '0;
      ext_re  = {{ABITS{s1_re[WIDTH-1]}}, s1_re};
      ext_im  = {{ABITS{s1_im[WIDTH-1]}}, s1_im};
      sum_re  = add_acc(base_re, ext_re);
      sum_im  = add_acc(base_im, ext_im);
      wr_en   = s1_valid && !s1_emit;
   end

   // Read-to-write distance is at least TRATE words, so no forwarding path is needed.
   always_ff @(posedge clock) begin
      if (bus.valid_i) begin
         rd_q <= mem[slot_q];
      end
      if (wr_en) begin
         mem[s1_slot] <= {sum_re, sum_im};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.valid_o <= 1'b0;
         bus.first_o <= 1'b0;
         bus.last_o  <= 1'b0;
         bus.error_o <= 1'b0;
         bus.slot_o  <= '0;
         bus.re_o    <= '0;
         bus.im_o    <= '0;
      end else begin
         bus.valid_o <= s1_valid && s1_emit;
         bus.error_o <= s1_valid && s1_err;
         if (s1_valid && s1_emit) begin
            bus.slot_o  <= s1_slot;
            bus.first_o <= (s1_slot == '0);
            bus.last_o  <= (s1_slot == LAST_SLOT);
            bus.re_o    <= sum_re;
            bus.im_o    <= sum_im;
         end
      end
   end
endmodule

// File: tb/tb_slot_accumulate.sv
// Scoreboard bench for slot_accumulate: default build plus a COUNT=4/ABITS=1 overflow instance.
module tb_slot_accumulate;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   slot_accumulate_if #(.WIDTH(4), .ACCUM(6), .TBITS(4)) bus ();
   slot_accumulate_if #(.WIDTH(4), .ACCUM(5), .TBITS(1)) bus2 ();

   slot_accumulate #(
      .WIDTH(4), .ABITS(2), .TRATE(12), .TBITS(4), .COUNT(3), .CBITS(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   slot_accumulate #(
      .WIDTH(4), .ABITS(1), .TRATE(2), .TBITS(1), .COUNT(4), .CBITS(2)
   ) dut2 (
      .clock(clock),
      .reset(reset),
      .bus  (bus2.slave)
   );

`ifdef SLOT_ACCUMULATE_SATURATE_EN
   localparam int RE2 = 15;
   localparam int IM2 = -16;
`else
   localparam int RE2 = -4;
   localparam int IM2 = 0;
`endif

   typedef struct {int slot; int re; int im; int cyc;} exp_t;
   exp_t exp_q[$];
   exp_t exp2_q[$];
   int   err_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (bus.valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected valid_o", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("slot_o", int'(bus.slot_o), e.slot);
            check("re_o", int'(bus.re_o), e.re);
            check("im_o", int'(bus.im_o), e.im);
            check("first_o", int'(bus.first_o), (e.slot == 0) ? 1 : 0);
            check("last_o", int'(bus.last_o), (e.slot == 11) ? 1 : 0);
            check("latency", cyc, e.cyc);
         end
      end
      if (bus.error_o) begin
         if (err_q.size() == 0) check("unexpected error_o", 1, 0);
         else check("error_o cycle", cyc, err_q.pop_front());
      end
      if (bus2.valid_o) begin
         if (exp2_q.size() == 0) begin
            check("unexpected valid_o dut2", 1, 0);
         end else begin
            e = exp2_q.pop_front();
            check("dut2 slot_o", int'(bus2.slot_o), e.slot);
            check("dut2 re_o", int'(bus2.re_o), e.re);
            check("dut2 im_o", int'(bus2.im_o), e.im);
            check("dut2 latency", cyc, e.cyc);
         end
      end
      if (bus2.error_o) check("unexpected error_o dut2", 1, 0);
   end

   task automatic send(input int re, input int im, input bit last, input bit emit,
                       input int ere, input int eim, input int slot, input bit err);
      @(posedge clock);
      #1;
      bus.valid_i = 1'b1;
      bus.last_i  = last;
      bus.re_i    = re[3:0];
      bus.im_i    = im[3:0];
      if (emit) exp_q.push_back('{slot, ere, eim, cyc + 2});
      if (err) err_q.push_back(cyc + 2);
   endtask

   task automatic send2(input int re, input int im, input bit last, input bit emit,
                        input int slot);
      @(posedge clock);
      #1;
      bus2.valid_i = 1'b1;
      bus2.last_i  = last;
      bus2.re_i    = re[3:0];
      bus2.im_i    = im[3:0];
      if (emit) exp2_q.push_back('{slot, RE2, IM2, cyc + 2});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         bus.valid_i  = 1'b0;
         bus.last_i   = 1'b0;
         bus2.valid_i = 1'b0;
         bus2.last_i  = 1'b0;
      end
   endtask

   // One accumulation period of slot-dependent data: re = slot-6, im = frame index.
   task automatic period(input bit gaps);
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 12; s++) begin
            send(s - 6, f, s == 11, f == 2, 3 * (s - 6), 3, s, 1'b0);
            if (gaps) idle($urandom_range(1, 3));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_i  = 1'b0;
      bus.last_i   = 1'b0;
      bus.re_i     = '0;
      bus.im_i     = '0;
      bus2.valid_i = 1'b0;
      bus2.last_i  = 1'b0;
      bus2.re_i    = '0;
      bus2.im_i    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset valid_o", int'(bus.valid_o), 0);
      check("reset error_o", int'(bus.error_o), 0);
      check("reset slot_o", int'(bus.slot_o), 0);
      check("reset re_o", int'(bus.re_o), 0);
      check("reset im_o", int'(bus.im_o), 0);
      check("reset first_o", int'(bus.first_o), 0);
      check("reset last_o", int'(bus.last_o), 0);
      check("reset dut2 valid_o", int'(bus2.valid_o), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Constant +1/-1 for three frames.
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 12; s++) send(1, -1, s == 11, f == 2, 3, -3, s, 1'b0);
      end
      idle(4);

      // Two back-to-back periods, then one with random gaps.
      period(1'b0);
      period(1'b0);
      idle(3);
      period(1'b1);
      idle(4);

      // Early last_i at slot 5 of frame 1.
      for (int s = 0; s < 12; s++) send(s - 6, 0, s == 11, 1'b0, 0, 0, s, 1'b0);
      for (int s = 0; s < 6; s++) send(s - 6, 1, s == 5, 1'b0, 0, 0, s, s == 5);
      period(1'b0);
      idle(4);

      // Reset right after slot 7 of frame 2: slot 7 is still in flight and must be dropped.
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 12; s++) send(s - 6, f, s == 11, 1'b0, 0, 0, s, 1'b0);
      end
      for (int s = 0; s < 8; s++) send(s - 6, 2, 1'b0, s <= 6, 3 * (s - 6), 3, s, 1'b0);
      @(posedge clock);
      #1;
      bus.valid_i = 1'b0;
      reset       = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle(2);
      period(1'b0);
      idle(4);

      // Overflow instance: +7/-8 summed over four frames in 5-bit accumulators.
      for (int f = 0; f < 4; f++) begin
         for (int s = 0; s < 2; s++) send2(7, -8, s == 1, f == 3, s);
      end
      idle(6);

      check("outputs outstanding", exp_q.size(), 0);
      check("dut2 outputs outstanding", exp2_q.size(), 0);
      check("error pulses outstanding", err_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/slot_accumulate.md
Name: slot_accumulate

Overview:
- Sits directly downstream of the correlator.
- Consumes its time-multiplexed stream of signed real/imaginary partial correlations: one word per baseline slot, TRATE slots per frame.
- Sums each slot over COUNT consecutive frames in an internal dual-port slot memory.
- Emits the widened visibility sums as a valid-qualified stream on the final frame, then restarts accumulation.

Parameters:
- WIDTH, 4, input word width (signed, two's complement), matches correlator output.
- ABITS, 2, accumulator growth bits; ACCUM = WIDTH + ABITS.
- TRATE, 12, slots per frame (>= 2).
- TBITS, 4, slot index width; 2^TBITS >= TRATE.
- COUNT, 3, frames summed per output (>= 1).
- CBITS, 2, frame counter width; 2^CBITS >= COUNT.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  input word valid.
- last_i  in  1  marks final slot of a frame; qualified by valid_i.
- re_i  in  WIDTH  signed real correlation term.
- im_i  in  WIDTH  signed imaginary correlation term.
- valid_o  out  1  output sum valid.
- first_o  out  1  output is slot 0.
- last_o  out  1  output is slot TRATE-1.
- slot_o  out  TBITS  slot index of output word.
- re_o  out  ACCUM  signed real sum.
- im_o  out  ACCUM  signed imaginary sum.
- error_o  out  1  one-cycle pulse on frame misalignment.

Behaviour:
- Reset:
  - valid_o, first_o, last_o, error_o = 0; slot_o, re_o, im_o = 0.
  - Slot counter = 0; frame counter = 0; FSM = FIRST; pipeline valids cleared.
  - Memory contents are don't-care; the FIRST state overwrites them.
- Slot counter:
  - Increments on every valid_i; wraps TRATE-1 -> 0.
  - Frame counter increments on the wrap and returns to 0 after COUNT-1.
- FSM, evaluated per valid_i:
  - FIRST (frame 0): write sign-extended input to mem[slot].
  - ACCUM (frames 1..COUNT-2): mem[slot] <= mem[slot] + sign-extended input.
  - EMIT (frame COUNT-1): output mem[slot] + input; no write required.
  - Transitions occur at the slot wrap: FIRST->ACCUM (COUNT>=3), FIRST->EMIT (COUNT=2), ACCUM->EMIT when the frame counter reaches COUNT-1, EMIT->FIRST.
  - COUNT=1: the FIRST/EMIT combination emits the sign-extended input directly, every frame.
- Pipeline, fixed latency 2 cycles from valid_i to valid_o:
  - Stage 1: memory read of mem[slot]; input, slot and flags registered.
  - Stage 2: add, then write-back or output register.
- Valid-only stream, no backpressure. Gaps in valid_i are allowed anywhere, and counters hold during gaps.
- Hazard: a read of a slot follows its write by at least TRATE valid cycles. TRATE >= 2 guarantees no read-modify-write collision, so no forwarding is needed.
- Outputs: slot_o, first_o (slot 0), last_o (slot TRATE-1), re_o, im_o are registered alongside valid_o. When valid_o = 0 they hold their previous values.
- Arithmetic: sign-extend WIDTH -> ACCUM before the add. Default behaviour is two's-complement wrap (see Optional Feature).
- Misalignment handling:
  - last_i = 1 with slot != TRATE-1: error_o pulses 2 cycles later. That word is still processed. Slot and frame counters then force to 0 and the FSM to FIRST; the partial accumulation is discarded.
  - Slot TRATE-1 reached with last_i = 0: the same error response, applied at the wrap.
- Reset mid-frame: pipeline words in flight are dropped (no valid_o); accumulation restarts at FIRST.

Optional Feature:
- Macro: SLOT_ACCUMULATE_SATURATE_EN.
- Defined: each add clamps to [-2^(ACCUM-1), 2^(ACCUM-1)-1] per component.
- Undefined: the add wraps modulo 2^ACCUM.
- Output latency and interface are identical in both builds.

Test Plan:
- Defaults, re_i = +1, im_i = -1 for all 36 words, last_i correct -> exactly 12 outputs; each re_o = 3, im_o = -3; slot_o 0..11; first_o on slot 0, last_o on slot 11; each output 2 cycles after its frame-2 input.
- Slot-dependent data, re_i = slot-6, im_i = frame, for 2 accumulation periods -> re_o = 3*(slot-6), im_o = 0+1+2 = 3 both periods; confirms state is cleared between periods.
- valid_i with random 1–3 cycle gaps, same data as above -> identical sums and order; latency stays 2 cycles per word.
- last_i asserted at slot 5 of frame 1 -> error_o pulse once; next valid_i treated as slot 0, frame 0; no valid_o until 3 clean frames complete, then correct sums.
- COUNT = 4, ABITS = 1, re_i = +7 -> wrap build: re_o = 28-32 = -4; SLOT_ACCUMULATE_SATURATE_EN build: re_o = +15.
- reset asserted for 1 cycle at slot 8 of frame 2 -> no valid_o for pending words; the next 3 full frames produce correct sums.
